// File: rtl/addr_trans_pkg.sv
// Shared definitions for the address translation MMU: TLB entry layout,
// exception codes and access/mode encodings.
package addr_trans_pkg;

  localparam int TLBE_W       = 83;
  localparam int TLBE_HALF_W  = 26;
  localparam int TLBE_H0_LO   = 0;
  localparam int TLBE_H1_LO   = 26;
  localparam int TLBE_G       = 52;
  localparam int TLBE_ASID_LO = 53;
  localparam int TLBE_VPPN_LO = 63;
  localparam int TLBE_E       = 82;

  // Bit offsets inside one 26-bit half-page descriptor
  localparam int HALF_V      = 0;
  localparam int HALF_D      = 1;
  localparam int HALF_MAT_LO = 2;
  localparam int HALF_PLV_LO = 4;
  localparam int HALF_PPN_LO = 6;

  localparam logic [5:0] ECODE_NONE = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_type_e;

  typedef enum logic {
    MODE_DA = 1'b0,
    MODE_PG = 1'b1
  } xlate_mode_e;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_half_t;

  function automatic tlb_half_t tlbe_half(input logic [TLBE_W-1:0] ent, input logic odd);
    tlb_half_t h;
    if (odd) begin
      h = ent[TLBE_H1_LO +: TLBE_HALF_W];
    end else begin
      h = ent[TLBE_H0_LO +: TLBE_HALF_W];
    end
    return h;
  endfunction

  // Invalid-page exception code depends on what the access was trying to do
  function automatic logic [5:0] inv_ecode(input logic [1:0] acc);
    logic [5:0] code;
    case (acc)
      ACC_FETCH: code = ECODE_PIF;
      ACC_STORE: code = ECODE_PIS;
      ACC_LOAD:  code = ECODE_PIL;
      default:   code = ECODE_PIL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/addr_trans_mmu_tlb_lookup.sv
// Combinational fully-associative TLB match for one virtual page number;
// the lowest matching entry index supplies the selected half-page.
module tlb_lookup
  import addr_trans_pkg::*;
#(
  parameter int TLB_ENTRIES = 16
) (
  input  logic [TLB_ENTRIES*TLBE_W-1:0] i_entries,
  input  logic [19:0]                   i_vpn,
  input  logic [9:0]                    i_asid,
  output logic                          o_hit,
  output tlb_half_t                     o_half
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  logic [TLB_ENTRIES-1:0] w_hit_vec;
  tlb_half_t              w_half [TLB_ENTRIES];
  logic [IDX_W-1:0]       w_sel;

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_ent
    logic [TLBE_W-1:0] w_ent;
    assign w_ent        = i_entries[i*TLBE_W +: TLBE_W];
    assign w_hit_vec[i] = w_ent[TLBE_E]
                        & (w_ent[TLBE_VPPN_LO +: 19] == i_vpn[19:1])
                        & (w_ent[TLBE_G] | (w_ent[TLBE_ASID_LO +: 10] == i_asid));
    assign w_half[i]    = tlbe_half(w_ent, i_vpn[0]);
  end

  // Priority select: scanning downward leaves the lowest hit index in w_sel
  always_comb begin
    w_sel = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      w_sel = w_hit_vec[i] ? IDX_W'(i) : w_sel;
    end
  end

  assign o_hit  = |w_hit_vec;
  assign o_half = w_half[w_sel];

endmodule

// File: rtl/addr_trans_mmu.sv
// Multi-channel virtual-to-physical address translator with DA, DMW and
// TLB paging modes; one registered response per accepted request.
module addr_trans_mmu
  import addr_trans_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int NUM_DMW     = 2,
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic [NUM_CH*32-1:0]    req_vaddr,
  input  logic [NUM_CH*2-1:0]     req_type,
  output logic [NUM_CH-1:0]       resp_valid,
  input  logic [NUM_CH-1:0]       resp_ready,
  output logic [NUM_CH*32-1:0]    resp_paddr,
  output logic [NUM_CH*2-1:0]     resp_mat,
  output logic [NUM_CH-1:0]       resp_exc,
  output logic [NUM_CH*6-1:0]     resp_ecode,
  input  logic                    csr_da,
  input  logic                    csr_pg,
  input  logic [1:0]              csr_plv,
  input  logic [1:0]              csr_datm,
  input  logic [9:0]              csr_asid,
  input  logic [NUM_DMW*32-1:0]   csr_dmw,
  input  logic                    tlb_we,
  input  logic [IDX_W-1:0]        tlb_windex,
  input  logic [TLBE_W-1:0]       tlb_wentry,
  input  logic                    tlb_inv_all
);

  localparam int DMW_IW = (NUM_DMW > 1) ? $clog2(NUM_DMW) : 1;

  logic [TLBE_W-1:0]             r_tlb [TLB_ENTRIES];
  logic [TLB_ENTRIES*TLBE_W-1:0] w_tlb_flat;
  xlate_mode_e                   w_mode;
  logic                          w_dmw_unused;

  // Only the legal paging combination enables translation; all others are DA
  assign w_mode = (!csr_da && csr_pg) ? MODE_PG : MODE_DA;

  for (genvar d = 0; d < NUM_DMW; d++) begin : g_dmw_unused
    logic w_bits_unused;
    assign w_bits_unused = ^{csr_dmw[32*d+28], csr_dmw[32*d+6 +: 19], csr_dmw[32*d+1 +: 2]};
  end
  assign w_dmw_unused = g_dmw_unused[0].w_bits_unused;

  // Entry storage: invalidate-all is applied before a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_tlb[i] <= '0;
      end
    end else begin
      if (tlb_inv_all) begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
          r_tlb[i][TLBE_E] <= 1'b0;
        end
      end
      if (tlb_we) begin
        r_tlb[tlb_windex] <= tlb_wentry;
      end
    end
  end

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_flat
    assign w_tlb_flat[i*TLBE_W +: TLBE_W] = r_tlb[i];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]        w_va;
    logic [1:0]         w_ty;
    logic               w_accept;
    logic               w_hit;
    tlb_half_t          w_half;
    logic [NUM_DMW-1:0] w_dmw_match;
    logic [DMW_IW-1:0]  w_dmw_sel;
    logic [31:0]        w_dmw_cfg;
    logic [31:0]        w_paddr;
    logic [1:0]         w_mat;
    logic               w_exc;
    logic [5:0]         w_ecode;
    logic               r_valid;
    logic [31:0]        r_paddr;
    logic [1:0]         r_mat;
    logic               r_exc;
    logic [5:0]         r_ecode;

    assign w_va     = req_vaddr[32*c +: 32];
    assign w_ty     = req_type[2*c +: 2];
    assign w_accept = req_valid[c] & req_ready[c];

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_lookup (
      .i_entries (w_tlb_flat),
      .i_vpn     (w_va[31:12]),
      .i_asid    (csr_asid),
      .o_hit     (w_hit),
      .o_half    (w_half)
    );

    for (genvar d = 0; d < NUM_DMW; d++) begin : g_dmw
      assign w_dmw_match[d] = (w_mode == MODE_PG)
                            & (w_va[31:29] == csr_dmw[32*d+29 +: 3])
                            & ((csr_dmw[32*d] & (csr_plv == 2'd0))
                              | (csr_dmw[32*d+3] & (csr_plv == 2'd3)));
    end

    // Lowest matching window index wins
    always_comb begin
      w_dmw_sel = '0;
      for (int d = NUM_DMW - 1; d >= 0; d--) begin
        w_dmw_sel = w_dmw_match[d] ? DMW_IW'(d) : w_dmw_sel;
      end
    end

    assign w_dmw_cfg = csr_dmw[32*w_dmw_sel +: 32];

    // Translation result; the TLB faults are checked in priority order
    always_comb begin
      w_paddr = w_va;
      w_mat   = 2'd0;
      w_exc   = 1'b0;
      w_ecode = ECODE_NONE;
      if (w_mode == MODE_DA) begin
        w_mat = csr_datm;
      end else if (|w_dmw_match) begin
        w_paddr = {w_dmw_cfg[27:25], w_va[28:0]};
        w_mat   = w_dmw_cfg[5:4];
      end else if (!w_hit) begin
        w_exc   = 1'b1;
        w_ecode = ECODE_TLBR;
      end else if (!w_half.v) begin
        w_exc   = 1'b1;
        w_ecode = inv_ecode(w_ty);
      end else if (csr_plv > w_half.plv) begin
        w_exc   = 1'b1;
        w_ecode = ECODE_PPI;
      end else if ((w_ty == ACC_STORE) && !w_half.d) begin
        w_exc   = 1'b1;
        w_ecode = ECODE_PME;
      end else begin
        w_paddr = {w_half.ppn, w_va[11:0]};
        w_mat   = w_half.mat;
      end
    end

    // Response register: loads on accept, holds while the consumer stalls
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_paddr <= 32'd0;
        r_mat   <= 2'd0;
        r_exc   <= 1'b0;
        r_ecode <= 6'd0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_paddr <= w_paddr;
        r_mat   <= w_mat;
        r_exc   <= w_exc;
        r_ecode <= w_ecode;
      end else if (resp_ready[c]) begin
        r_valid <= 1'b0;
      end
    end

    assign req_ready[c]          = ~r_valid | resp_ready[c];
    assign resp_valid[c]         = r_valid;
    assign resp_paddr[32*c +: 32] = r_paddr;
    assign resp_mat[2*c +: 2]     = r_mat;
    assign resp_exc[c]           = r_exc;
    assign resp_ecode[6*c +: 6]   = r_ecode;
  end

endmodule

// File: tb/tb_addr_trans_mmu.sv
// Directed plus randomized bench for addr_trans_mmu, scored against a
// behavioural translation model with a per-channel response scoreboard.
module tb_addr_trans_mmu;
  import addr_trans_pkg::*;

  localparam int NCH = 2;
  localparam int NDMW = 2;
  localparam int NE = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NCH-1:0]     req_valid, req_ready, resp_valid, resp_ready, resp_exc;
  logic [NCH*32-1:0]  req_vaddr, resp_paddr;
  logic [NCH*2-1:0]   req_type, resp_mat;
  logic [NCH*6-1:0]   resp_ecode;
  logic               csr_da, csr_pg;
  logic [1:0]         csr_plv, csr_datm;
  logic [9:0]         csr_asid;
  logic [NDMW*32-1:0] csr_dmw;
  logic               tlb_we, tlb_inv_all;
  logic [IW-1:0]      tlb_windex;
  logic [TLBE_W-1:0]  tlb_wentry;

  addr_trans_mmu #(.NUM_CH(NCH), .NUM_DMW(NDMW), .TLB_ENTRIES(NE), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_type(req_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_mat(resp_mat), .resp_exc(resp_exc), .resp_ecode(resp_ecode),
    .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv), .csr_datm(csr_datm),
    .csr_asid(csr_asid), .csr_dmw(csr_dmw),
    .tlb_we(tlb_we), .tlb_windex(tlb_windex), .tlb_wentry(tlb_wentry), .tlb_inv_all(tlb_inv_all)
  );

  typedef struct packed {
    logic [19:0] ppn; logic [1:0] plv; logic [1:0] mat; logic d; logic v;
  } mhalf_t;
  typedef struct packed {
    logic e; logic [18:0] vppn; logic [9:0] asid; logic g; mhalf_t odd; mhalf_t even;
  } ment_t;
  typedef struct packed {
    logic [31:0] paddr; logic [1:0] mat; logic exc; logic [5:0] ecode;
  } res_t;

  ment_t          m_tlb [NE];
  ment_t          wr_ent;
  logic [NCH-1:0] exp_valid;
  res_t           exp_res [NCH];
  int             n_tests = 0;
  int             n_fail = 0;

  function automatic logic [TLBE_W-1:0] pack(input ment_t x);
    logic [TLBE_W-1:0] w;
    mhalf_t h;
    int b;
    w = '0;
    w[TLBE_E] = x.e;
    w[TLBE_VPPN_LO +: 19] = x.vppn;
    w[TLBE_ASID_LO +: 10] = x.asid;
    w[TLBE_G] = x.g;
    for (int k = 0; k < 2; k++) begin
      h = (k == 0) ? x.even : x.odd;
      b = (k == 0) ? TLBE_H0_LO : TLBE_H1_LO;
      w[b + HALF_V] = h.v;
      w[b + HALF_D] = h.d;
      w[b + HALF_MAT_LO +: 2] = h.mat;
      w[b + HALF_PLV_LO +: 2] = h.plv;
      w[b + HALF_PPN_LO +: 20] = h.ppn;
    end
    return w;
  endfunction

  function automatic res_t ref_xlate(input logic [31:0] va, input logic [1:0] ty);
    res_t r;
    int hit;
    mhalf_t h;
    logic [31:0] dmw;
    r.paddr = va; r.mat = csr_datm; r.exc = 1'b0; r.ecode = 6'h00;
    if (csr_da || !csr_pg) return r;
    for (int i = 0; i < NDMW; i++) begin
      dmw = csr_dmw[i*32 +: 32];
      if (va[31:29] == dmw[31:29] &&
          ((dmw[0] && csr_plv == 2'd0) || (dmw[3] && csr_plv == 2'd3))) begin
        r.paddr = {dmw[27:25], va[28:0]};
        r.mat = dmw[5:4];
        return r;
      end
    end
    hit = -1;
    for (int i = 0; i < NE; i++) begin
      if (hit < 0 && m_tlb[i].e && m_tlb[i].vppn == va[31:13] &&
          (m_tlb[i].g || m_tlb[i].asid == csr_asid)) hit = i;
    end
    r.mat = 2'd0;
    r.exc = 1'b1;
    if (hit < 0) begin
      r.ecode = 6'h3F;
      return r;
    end
    h = va[12] ? m_tlb[hit].odd : m_tlb[hit].even;
    if (!h.v) r.ecode = (ty == 2'd0) ? 6'h03 : ((ty == 2'd2) ? 6'h02 : 6'h01);
    else if (csr_plv > h.plv) r.ecode = 6'h07;
    else if (ty == 2'd2 && !h.d) r.ecode = 6'h04;
    else begin
      r.exc = 1'b0; r.ecode = 6'h00; r.paddr = {h.ppn, va[11:0]}; r.mat = h.mat;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake, predict, clock, update model, check outputs
  task automatic cycle();
    res_t nxt [NCH];
    logic [NCH-1:0] acc;
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (!rst) chk($sformatf("req_ready%0d", c), 32'(req_ready[c]), 32'(!exp_valid[c] || resp_ready[c]));
      acc[c] = req_valid[c] && (!exp_valid[c] || resp_ready[c]);
      nxt[c] = acc[c] ? ref_xlate(req_vaddr[c*32 +: 32], req_type[c*2 +: 2]) : exp_res[c];
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_valid = '0;
      for (int c = 0; c < NCH; c++) exp_res[c] = '0;
      for (int i = 0; i < NE; i++) m_tlb[i] = '0;
    end else begin
      if (tlb_inv_all) for (int i = 0; i < NE; i++) m_tlb[i].e = 1'b0;
      if (tlb_we) m_tlb[tlb_windex] = wr_ent;
      for (int c = 0; c < NCH; c++) begin
        if (acc[c]) begin
          exp_valid[c] = 1'b1;
          exp_res[c] = nxt[c];
        end else if (resp_ready[c]) exp_valid[c] = 1'b0;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("resp_valid%0d", c), 32'(resp_valid[c]), 32'(exp_valid[c]));
      if (exp_valid[c]) begin
        chk($sformatf("paddr%0d", c), resp_paddr[c*32 +: 32], exp_res[c].paddr);
        chk($sformatf("mat_exc_ecode%0d", c),
            32'({resp_mat[c*2 +: 2], resp_exc[c], resp_ecode[c*6 +: 6]}),
            32'({exp_res[c].mat, exp_res[c].exc, exp_res[c].ecode}));
      end
    end
  endtask

  task automatic req(input int c, input logic [31:0] va, input logic [1:0] ty);
    req_valid[c] = 1'b1;
    req_vaddr[c*32 +: 32] = va;
    req_type[c*2 +: 2] = ty;
  endtask

  task automatic idle();
    req_valid = '0; tlb_we = 1'b0; tlb_inv_all = 1'b0;
  endtask

  task automatic write_tlb(input int idx);
    tlb_we = 1'b1; tlb_windex = IW'(idx); tlb_wentry = pack(wr_ent);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] dw;
    rst = 1'b1; idle(); req_vaddr = '0; req_type = '0; resp_ready = '1;
    csr_da = 1'b1; csr_pg = 1'b0; csr_plv = 2'd0; csr_datm = 2'd0; csr_asid = 10'd0;
    csr_dmw = '0; tlb_windex = '0; tlb_wentry = '0; wr_ent = '0; exp_valid = '0;
    for (int c = 0; c < NCH; c++) exp_res[c] = '0;
    for (int i = 0; i < NE; i++) m_tlb[i] = '0;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_paddr", resp_paddr[31:0] | resp_paddr[63:32], 32'd0);
    chk("rst_misc", 32'({resp_mat, resp_exc, resp_ecode}), 32'd0);

    // DA mode
    csr_datm = 2'd1;
    req(1, 32'h1C00_0010, 2'd1); cycle(); idle();
    chk("da_paddr", resp_paddr[63:32], 32'h1C00_0010);
    chk("da_mat", 32'(resp_mat[3:2]), 32'd1);
    chk("da_exc", 32'(resp_exc[1]), 32'd0);

    // DMW window, then the same access at a privilege the window excludes
    csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_dmw = {32'h0, 32'hA000_0011};
    req(1, 32'hA123_4568, 2'd1); cycle(); idle();
    chk("dmw_paddr", resp_paddr[63:32], 32'h0123_4568);
    chk("dmw_mat", 32'(resp_mat[3:2]), 32'd1);
    csr_plv = 2'd3;
    req(1, 32'hA123_4568, 2'd1); cycle(); idle();
    chk("dmw_plv3_ecode", 32'(resp_ecode[11:6]), 32'h3F);

    // TLB hit and ASID miss
    wr_ent = '0; wr_ent.e = 1'b1; wr_ent.vppn = 19'h00020; wr_ent.asid = 10'd5;
    wr_ent.odd = '{ppn: 20'h12345, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    write_tlb(3); cycle(); idle();
    csr_asid = 10'd5;
    req(1, 32'h0004_1ABC, 2'd2); cycle(); idle();
    chk("tlb_hit_paddr", resp_paddr[63:32], 32'h1234_5ABC);
    chk("tlb_hit_exc", 32'(resp_exc[1]), 32'd0);
    csr_asid = 10'd6;
    req(1, 32'h0004_1ABC, 2'd2); cycle(); idle();
    chk("tlb_asid_miss", 32'(resp_ecode[11:6]), 32'h3F);
    csr_asid = 10'd5;

    // Fault ladder on the same entry
    wr_ent.odd.d = 1'b0; write_tlb(3); cycle(); idle();
    req(1, 32'h0004_1ABC, 2'd2); cycle(); idle();
    chk("pme", 32'(resp_ecode[11:6]), 32'h04);
    wr_ent.odd.d = 1'b1; wr_ent.odd.v = 1'b0; write_tlb(3); cycle(); idle();
    req(0, 32'h0004_1ABC, 2'd0); cycle(); idle();
    chk("pif", 32'(resp_ecode[5:0]), 32'h03);
    chk("pif_paddr", resp_paddr[31:0], 32'h0004_1ABC);
    wr_ent.odd.v = 1'b1; wr_ent.odd.plv = 2'd0; write_tlb(3); cycle(); idle();
    req(1, 32'h0004_1ABC, 2'd1); cycle(); idle();
    chk("ppi", 32'(resp_ecode[11:6]), 32'h07);
    wr_ent.odd.plv = 2'd3; write_tlb(3); cycle(); idle();

    // Backpressure: hold for three cycles, then release
    resp_ready = 2'b00;
    req(1, 32'h0004_1ABC, 2'd1); cycle();
    req(1, 32'h0004_1004, 2'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_paddr", resp_paddr[63:32], 32'h1234_5ABC);
      chk("bp_ready_low", 32'(req_ready[1]), 32'd0);
    end
    resp_ready = 2'b11; cycle(); idle();
    chk("bp_release", resp_paddr[63:32], 32'h1234_5004);
    cycle();

    // Write racing a lookup sees old contents
    wr_ent.odd.ppn = 20'h54321; write_tlb(3);
    req(1, 32'h0004_1ABC, 2'd1); cycle(); idle();
    chk("race_old", resp_paddr[63:32], 32'h1234_5ABC);
    req(1, 32'h0004_1ABC, 2'd1); cycle(); idle();
    chk("race_new", resp_paddr[63:32], 32'h5432_1ABC);

    // Invalidate-all with write: only the written entry survives
    wr_ent = '0; wr_ent.e = 1'b1; wr_ent.vppn = 19'h00021; wr_ent.asid = 10'd5;
    wr_ent.even = '{ppn: 20'h0ABCD, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
    write_tlb(2); tlb_inv_all = 1'b1; cycle(); idle();
    req(0, 32'h0004_2010, 2'd1); req(1, 32'h0004_1ABC, 2'd1); cycle(); idle();
    chk("inv_keep", resp_paddr[31:0], 32'h0ABC_D010);
    chk("inv_drop", 32'(resp_ecode[11:6]), 32'h3F);

    // Reset while stalled drops the pending response
    resp_ready = 2'b00;
    req(0, 32'h0004_2010, 2'd1); cycle(); idle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_stall", 32'(resp_valid), 32'd0);
    resp_ready = 2'b11;

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      idle();
      rnd = $urandom;
      csr_da = (rnd[2:0] == 3'd0) ? rnd[3] : 1'b0;
      csr_pg = (rnd[2:0] == 3'd0) ? rnd[4] : 1'b1;
      csr_plv = rnd[6:5];
      csr_datm = rnd[8:7];
      csr_asid = rnd[9] ? 10'd5 : 10'd6;
      if (rnd[13:10] == 4'd0) begin
        for (int d = 0; d < NDMW; d++) begin
          dw = $urandom;
          dw[31:29] = 3'($urandom_range(0, 2));
          csr_dmw[d*32 +: 32] = dw;
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        rnd = $urandom;
        wr_ent.e = (rnd[2:0] != 3'd0);
        wr_ent.vppn = 19'h00020 + 19'(rnd[4:3]);
        wr_ent.asid = rnd[5] ? 10'd5 : 10'd6;
        wr_ent.g = rnd[6];
        wr_ent.even = mhalf_t'($urandom);
        wr_ent.odd = mhalf_t'($urandom);
        wr_ent.even.v = (rnd[9:8] != 2'd0);
        wr_ent.odd.v = (rnd[11:10] != 2'd0);
        write_tlb($urandom_range(0, 7));
      end
      tlb_inv_all = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) begin
        rnd = $urandom;
        req_valid[c] = (rnd[1:0] != 2'd0);
        req_vaddr[c*32 +: 32] = rnd[2] ? $urandom
                                      : {19'h00020 + 19'(rnd[4:3]), rnd[17:5]};
        req_type[c*2 +: 2] = 2'($urandom_range(0, 2));
        resp_ready[c] = (rnd[19:18] != 2'd0);
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_trans_mmu.md
Name: addr_trans_mmu

Overview:
- Parametrised successor to the single-channel, DMW-only data address translator; sits between the pipeline AGU/fetch stages and the I/D cache request ports.
- Translates NUM_CH independent virtual-address streams in direct (DA), direct-mapped-window (DMW) or page (TLB) mode.
- Produces physical address, memory access type (MAT) and a translation exception per request, one cycle after acceptance.
- Contains a small fully-associative 4 KB-page TLB with a write port and an invalidate-all operation.

Parameters:
- NUM_CH, 2, number of independent translation channels (ch0 = fetch, ch1 = load/store by convention).
- NUM_DMW, 2, number of direct-mapped windows.
- TLB_ENTRIES, 16, number of TLB entries (power of two, at least 2).
- IDX_W, $clog2(TLB_ENTRIES), TLB index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel accept
- req_vaddr  in  NUM_CH*32  virtual addresses, channel i at [32i+31:32i]
- req_type  in  NUM_CH*2  access type: 0 = fetch, 1 = load, 2 = store
- resp_valid  out  NUM_CH  result valid
- resp_ready  in  NUM_CH  consumer accept
- resp_paddr  out  NUM_CH*32  physical address
- resp_mat  out  NUM_CH*2  memory access type
- resp_exc  out  NUM_CH  translation exception flag
- resp_ecode  out  NUM_CH*6  exception code
- csr_da, csr_pg  in  1 each  CRMD.DA / CRMD.PG
- csr_plv  in  2  current privilege level
- csr_datm  in  2  MAT used in DA mode
- csr_asid  in  10  current ASID
- csr_dmw  in  NUM_DMW*32  DMW CSRs
- tlb_we  in  1  write TLB entry
- tlb_windex  in  IDX_W  entry to write
- tlb_wentry  in  TLBE_W  packed entry (package format)
- tlb_inv_all  in  1  clear E bit of every entry

Behaviour:
- Reset: resp_valid = 0, resp_paddr = 0, resp_mat = 0, resp_exc = 0, resp_ecode = 0, all TLB E bits = 0.
- Handshake, per channel:
  - req_ready = !resp_valid | resp_ready.
  - A request is accepted when req_valid & req_ready.
  - Result is registered and visible the next cycle (latency 1).
  - Outputs hold stable while resp_valid & !resp_ready.
  - Full throughput when resp_ready is held at 1.
  - Channels are independent; no cross-channel stall.
- Mode selection, sampled in the accept cycle:
  - DA: csr_da = 1 and csr_pg = 0. paddr = vaddr, mat = csr_datm, no exception.
  - PG: csr_da = 0 and csr_pg = 1.
  - Any other combination behaves as DA.
- DMW i matches when all of the following hold:
  - PG mode;
  - vaddr[31:29] == dmw[31:29];
  - (dmw[0] & plv == 0) | (dmw[3] & plv == 3).
  - On a match: paddr = {dmw[27:25], vaddr[28:0]}, mat = dmw[5:4], no exception. The lowest matching index wins.
- TLB lookup (PG mode, no DMW match):
  - Entry hit: E & (vppn == vaddr[31:13]) & (G | asid == csr_asid).
  - Half-page selected by vaddr[12]. Lowest hit index wins on multi-hit.
  - paddr = {ppn, vaddr[11:0]}, mat = half MAT.
- Exception priority, TLB path only:
  1. No hit -> TLBR (0x3F).
  2. V = 0 -> PIF (0x03) for fetch, PIL (0x01) for load, PIS (0x02) for store.
  3. csr_plv > half PLV -> PPI (0x07).
  4. Store with D = 0 -> PME (0x04).
  - On any exception, paddr = vaddr and mat = 0.
- TLB write/invalidate:
  - Takes effect on the next clock edge.
  - A lookup accepted in the same cycle sees the old contents.
  - tlb_inv_all together with tlb_we: the invalidate applies first, then the write, so the written entry ends valid.
- Reset mid-operation: pending responses are dropped; no partial results.

Decomposition:
- Package addr_trans_pkg holds:
  - TLB entry field offsets: e, vppn[18:0], asid[9:0], g, and for each of the two halves ppn[19:0], plv[1:0], mat[1:0], d, v. TLBE_W = 83.
  - Ecode constants.
  - Access-type and mode encodings.
- Sub-module tlb_lookup: combinational match-and-select for one vaddr against the entry array, instantiated NUM_CH times.
- The entry storage and write/invalidate logic stay in the top module.

Test Plan:
- DA: csr_da = 1, csr_pg = 0, csr_datm = 1, ch1 load 0x1C00_0010 -> next cycle paddr 0x1C00_0010, mat 1, exc 0.
- DMW: PG mode, plv 0, dmw0 = 0xA000_0011, load 0xA123_4568 -> paddr 0x0123_4568, mat 1. Same access at plv 3 -> TLBR 0x3F.
- TLB hit: write idx 3 with vppn 0x00020, asid 5, g 0, odd half ppn 0x12345, v 1, d 1, plv 3; store 0x0004_1ABC with asid 5 -> paddr 0x1234_5ABC. With asid 6 -> TLBR.
- Faults on the same entry:
  - d = 0 store -> PME 0x04.
  - v = 0 fetch -> PIF 0x03.
  - Entry plv 0, csr_plv 3 -> PPI 0x07.
- Backpressure: resp_ready = 0 for 3 cycles with a new req pending -> outputs held, req_ready = 0. Release -> queued request completes the following cycle.
- Write/invalidate races:
  - tlb_we to idx 3 in the same cycle as a lookup hitting old idx 3 -> old translation returned.
  - tlb_inv_all together with tlb_we idx 2 -> only idx 2 valid afterwards.
  - rst mid-stall -> resp_valid 0.
